// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, frame constants and parity helper
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 14;
    localparam int DATA_BITS            = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // odd=1 inverts the even-parity result
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter, bit_tick on the last clock of each period
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 14
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART frame transmitter: start, 8 data MSB first, parity, stop bit(s)
// UART_TX_ODD_PARITY_EN selects odd parity; even parity otherwise.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk_3125,
    input  logic                 rst_n,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

`ifdef UART_TX_ODD_PARITY_EN
    localparam logic ODD_PARITY = 1'b1;
`else
    localparam logic ODD_PARITY = 1'b0;
`endif

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 bit_tick;
    logic                 baud_clr;

    // Counter is held at zero while idle so the start bit gets a full period from the accept edge
    assign baud_clr = (state_q == IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk_3125),
        .rst_n    (rst_n),
        .en       (!baud_clr),
        .clr      (baud_clr),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (tx_start) begin
                    shift_d   = tx_data;
                    parity_d  = calc_parity(tx_data, ODD_PARITY);
                    bit_idx_d = '0;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_tick) begin
                    tx_d      = shift_q[DATA_BITS-1];
                    shift_d   = {shift_q[DATA_BITS-2:0], 1'b0};
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_idx_q == LAST_DATA) begin
                        tx_d    = parity_q;
                        state_d = PARITY;
                    end else begin
                        tx_d      = shift_q[DATA_BITS-1];
                        shift_d   = {shift_q[DATA_BITS-2:0], 1'b0};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    tx_d      = 1'b1;
                    bit_idx_d = '0;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (bit_idx_q == LAST_STOP) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter stage; it generates the frames that the uart_rx block consumes.
- Accepts a byte through a start/busy handshake and serialises one frame on a single line, each bit lasting CLKS_PER_BIT clocks of clk_3125.
- Frame format: start (0), 8 data bits MSB first, parity bit (XOR of data), STOP_BITS stop bits (1).
- Line idles high.

Parameters:
- CLKS_PER_BIT, 14: clocks per bit period (3.125 MHz / 14). Legal range is >= 2.
- STOP_BITS, 1: number of stop bits. Legal values are 1 or 2.

Ports:
- clk_3125  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_start  input  1  request to send tx_data; sampled only when tx_busy=0.
- tx_data  input  8  byte to send; captured on the accepting edge.
- tx  output  1  serial line, idle high.
- tx_busy  output  1  high while a frame is in progress.
- tx_done  output  1  one-cycle pulse after the last stop bit completes.

Behaviour:
- Reset (async assert, sync-free deassert):
  - tx=1, tx_busy=0, tx_done=0.
  - State IDLE; counters and shift register cleared.
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE: tx=1, tx_busy=0.
  - At edge T0 with tx_start=1: latch tx_data into a shift register, compute parity=^tx_data, go to START.
  - From T0 onwards: tx=0, tx_busy=1.
- Bit timing:
  - The baud counter runs 0..CLKS_PER_BIT-1; each bit holds tx constant for exactly CLKS_PER_BIT cycles. Let C = CLKS_PER_BIT.
  - Start bit: cycles T0+1..T0+C.
  - Data bit i (i=0 is bit 7): starts at cycle T0+1+C*(1+i).
  - Parity bit: starts at T0+1+9C.
  - Stop bit(s): start at T0+1+10C; tx=1.
- End of frame, at edge T0+(10+STOP_BITS)*C:
  - State returns to IDLE; tx_done=1 for that single cycle; tx_busy=0 in the same cycle.
  - Frame length is therefore (10+STOP_BITS)*C cycles.
- Back-to-back: tx_start=1 during the tx_done cycle is accepted at the next edge. The minimum idle-line gap is 1 cycle.
- tx_start while tx_busy=1 is ignored, not queued. tx_data changes while busy have no effect.
- Reset mid-frame: tx forced to 1 immediately, frame aborted, no tx_done.
- Counter widths: $clog2(CLKS_PER_BIT) for the baud counter, 3 bits for the bit index. No wrap beyond the defined terminal counts.

Optional Feature:
- Macro: UART_TX_ODD_PARITY_EN.
- Defined: parity bit = ~^data (odd parity).
- Undefined: parity bit = ^data (even parity), which is what uart_rx checks against.
- Timing is identical in both cases.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE/START/DATA/PARITY/STOP);
  - DEFAULT_CLKS_PER_BIT=14;
  - DATA_BITS=8;
  - the parity function.
  uart_rx shares the package.
- One sub-module, uart_baud_gen:
  - a parameterised counter with an enable/clear input;
  - emits bit_tick on terminal count;
  - reused by the transmitter and later receivers.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles while tx_start=1 -> tx=1, tx_busy=0, tx_done=0 throughout; no frame after release until a new tx_start.
- Send 8'hA5, C=14:
  - tx sequence 0,1,0,1,0,0,1,0,1, parity 0, stop 1, each level held exactly 14 cycles;
  - tx_done pulse 154 cycles after the accept edge.
- Send 8'h07:
  - parity bit=1;
  - with UART_TX_ODD_PARITY_EN defined, parity bit=0;
  - all other bits unchanged.
- Busy/back-to-back:
  - pulse tx_start with 8'h11 mid-frame of 8'h3C -> ignored;
  - tx_start held through the tx_done cycle with 8'h11 -> second frame's start bit begins 1 cycle after tx_done.
- Reset mid-frame: assert rst_n=0 during data bit 3 -> tx=1 within the same cycle, no tx_done; the next frame after release is correct.
- Loopback into uart_rx, frames 8'h3C, 8'hFF, 8'h00, separated by >= 28 idle cycles -> rx_msg matches each byte; rx_parity = 0, 0, 0; one rx_complete per frame.
